// File: rtl/mult_share_arb.sv
// Round-robin arbiter time-sharing one pipelined signed multiplier among R requesters.
// A tag pipeline shadows the multiplier so every product is strobed back to its issuer.
module mult_share_arb #(
    parameter int R   = 4,
    parameter int M   = 5,
    parameter int N   = 4,
    parameter int LAT = 6,
    parameter int TW  = $clog2(R)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [R-1:0]     req_valid,
    input  logic [R*M-1:0]   req_a,
    input  logic [R*N-1:0]   req_b,
    output logic [R-1:0]     req_ready,
    output logic [R-1:0]     res_valid,
    output logic [M+N-1:0]   res_data,
    output logic             mult_in_valid,
    output logic [M-1:0]     mult_in_a,
    output logic [N-1:0]     mult_in_b,
    input  logic             mult_out_valid,
    input  logic [M+N-1:0]   mult_out,
    output logic             busy,
    output logic             err
);

    localparam logic [R-1:0] ONE_R = 1;

    logic [TW-1:0]  ptr_q, ptr_d;
    logic [R-1:0]   grant;
    logic [TW-1:0]  grantIdx;
    logic           found;
    logic           handshake;
    int             scanIdx;

    logic           inValid_q;
    logic [M-1:0]   inA_q;
    logic [N-1:0]   inB_q;
    logic [TW-1:0]  inTag_q;

    logic [LAT-1:0] tagValid_q;
    logic [TW-1:0]  tagId_q [LAT];

    logic           headValid;
    logic [TW-1:0]  headTag;
    logic           resHit;
    logic [R-1:0]   resValid_q, resValid_d;
    logic [M+N-1:0] resData_q;
    logic           err_q;

    // First requester at or after the pointer, scanning cyclically.
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        scanIdx  = 0;
        for (int i = 0; i < R; i++) begin
            scanIdx = (int'(ptr_q) + i) % R;
            if (!found && req_valid[scanIdx]) begin
                found           = 1'b1;
                grant[scanIdx]  = 1'b1;
                grantIdx        = TW'(scanIdx);
            end
        end
    end

    assign req_ready = rst ? '0 : grant;
    assign handshake = |(req_valid & req_ready);

    always_comb begin
        ptr_d = ptr_q;
        if (handshake) begin
            ptr_d = (grantIdx == TW'(R - 1)) ? '0 : grantIdx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            inValid_q <= 1'b0;
            inA_q     <= '0;
            inB_q     <= '0;
            inTag_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            inValid_q <= handshake;
            if (handshake) begin
                inA_q   <= req_a[grantIdx*M +: M];
                inB_q   <= req_b[grantIdx*N +: N];
                inTag_q <= grantIdx;
            end
        end
    end

    // The issue register acts as the entry stage, so after LAT more stages the
    // head lines up with the multiplier output LAT cycles after mult_in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tagValid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                tagId_q[i] <= '0;
            end
        end else begin
            tagValid_q <= {tagValid_q[LAT-2:0], inValid_q};
            tagId_q[0] <= inTag_q;
            for (int i = 1; i < LAT; i++) begin
                tagId_q[i] <= tagId_q[i-1];
            end
        end
    end

    assign headValid  = tagValid_q[LAT-1];
    assign headTag    = tagId_q[LAT-1];
    assign resHit     = mult_out_valid & headValid;
    assign resValid_d = resHit ? (ONE_R << headTag) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resValid_q <= '0;
            resData_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            resValid_q <= resValid_d;
            if (resHit) begin
                resData_q <= mult_out;
            end
            if (mult_out_valid != headValid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign mult_in_valid = inValid_q;
    assign mult_in_a     = inA_q;
    assign mult_in_b     = inB_q;
    assign res_valid     = resValid_q;
    assign res_data      = resData_q;
    assign err           = err_q;
    assign busy          = inValid_q | (|tagValid_q) | (|resValid_q);

endmodule

// File: tb/tb_mult_share_arb.sv
// Testbench for mult_share_arb: behavioural LAT-cycle signed multiplier, directed
// vector table, multi-cycle corner sequences and a random soak with an in-order scoreboard.
module tb_mult_share_arb;

   localparam int R   = 4;
   localparam int M   = 5;
   localparam int N   = 4;
   localparam int LAT = 6;
   localparam int TW  = 2;
   localparam int W   = M + N;

   logic           clk = 1'b0;
   logic           rst;
   logic [R-1:0]   req_valid;
   logic [R*M-1:0] req_a;
   logic [R*N-1:0] req_b;
   logic [R-1:0]   req_ready;
   logic [R-1:0]   res_valid;
   logic [W-1:0]   res_data;
   logic           mult_in_valid;
   logic [M-1:0]   mult_in_a;
   logic [N-1:0]   mult_in_b;
   logic           mult_out_valid;
   logic [W-1:0]   mult_out;
   logic           busy;
   logic           err;
   logic           forceOutValid;

   typedef struct {
      int           req;
      logic [M-1:0] a;
      logic [N-1:0] b;
      logic [W-1:0] prod;
   } vec_t;

   typedef struct {
      int           tag;
      logic [W-1:0] prod;
   } exp_t;

   vec_t vecs [7];
   exp_t expQ [$];
   int   vectors = 0;
   int   miscompares = 0;

   logic [M-1:0] cA [8];
   logic [N-1:0] cB [8];

   mult_share_arb #(.R(R), .M(M), .N(N), .LAT(LAT), .TW(TW)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_ready      (req_ready),
      .res_valid      (res_valid),
      .res_data       (res_data),
      .mult_in_valid  (mult_in_valid),
      .mult_in_a      (mult_in_a),
      .mult_in_b      (mult_in_b),
      .mult_out_valid (mult_out_valid),
      .mult_out       (mult_out),
      .busy           (busy),
      .err            (err)
   );

   // Free-running clock
   always #5 clk = ~clk;

   function automatic logic [W-1:0] refProduct(input logic [M-1:0] a, input logic [N-1:0] b);
      logic signed [W-1:0] p;
      p = $signed(a) * $signed(b);
      return p;
   endfunction

   // Stand-in for the shared multiplier: fixed LAT-cycle delay line, no stall
   logic [LAT-1:0] modelValid;
   logic [W-1:0]   modelProd [LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         modelValid <= '0;
         for (int i = 0; i < LAT; i++) modelProd[i] <= '0;
      end else begin
         modelValid   <= {modelValid[LAT-2:0], mult_in_valid};
         modelProd[0] <= refProduct(mult_in_a, mult_in_b);
         for (int i = 1; i < LAT; i++) modelProd[i] <= modelProd[i-1];
      end
   end

   assign mult_out_valid = modelValid[LAT-1] | forceOutValid;
   assign mult_out       = modelProd[LAT-1];

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout, expected normal completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
      end
   endtask

   task automatic applyStimulus(input int k, input logic [M-1:0] a, input logic [N-1:0] b);
      req_a[k*M +: M] = a;
      req_b[k*N +: N] = b;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle sample: records handshakes and checks returned results in issue order
   task automatic settle();
      logic [R-1:0] hs;
      exp_t         e;
      @(negedge clk);
      if (rst) begin
         expQ.delete();
         return;
      end
      checkOutput("ready onehot0", {31'b0, $onehot0(req_ready)}, 32'd1);
      checkOutput("ready iff valid", {31'b0, |req_ready}, {31'b0, |req_valid});
      hs = req_valid & req_ready;
      for (int k = 0; k < R; k++) begin
         if (hs[k]) begin
            e.tag  = k;
            e.prod = refProduct(req_a[k*M +: M], req_b[k*N +: N]);
            expQ.push_back(e);
         end
      end
      if (res_valid != '0) begin
         if (!$onehot(res_valid)) begin
            checkOutput("res_valid onehot", {28'b0, res_valid}, 32'd0);
         end else if (expQ.size() == 0) begin
            checkOutput("unexpected res_valid", {28'b0, res_valid}, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("result tag", {28'b0, res_valid}, 32'd1 << e.tag);
            checkOutput("result data", {23'b0, res_data}, {23'b0, e.prod});
         end
      end
   endtask

   task automatic doReset();
      nextCycle();
      rst = 1'b1;
      settle();
      nextCycle();
      rst = 1'b0;
   endtask

   initial begin
      logic [R-1:0] pending;
      logic [R-1:0] hsSeen;
      int           lat;
      int           idx;
      bit           found;

      rst           = 1'b1;
      req_valid     = '1;
      req_a         = '0;
      req_b         = '0;
      forceOutValid = 1'b0;

      vecs[0] = '{2, 5'h1D, 4'h5, 9'h1F1};
      vecs[1] = '{0, 5'h10, 4'h8, 9'h080};
      vecs[2] = '{1, 5'h0F, 4'h7, 9'h069};
      vecs[3] = '{3, 5'h10, 4'h7, 9'h190};
      vecs[4] = '{2, 5'h0F, 4'h8, 9'h188};
      vecs[5] = '{1, 5'h1F, 4'hF, 9'h001};
      vecs[6] = '{3, 5'h00, 4'h9, 9'h000};

      cA = '{5'h0A, 5'h10, 5'h07, 5'h1B, 5'h0F, 5'h03, 5'h10, 5'h00};
      cB = '{4'h3,  4'h8,  4'hE,  4'h6,  4'h7,  4'h8,  4'h8,  4'hF};

      // Reset state, with every requester asking
      settle();
      checkOutput("reset req_ready", {28'b0, req_ready}, 32'd0);
      checkOutput("reset res_valid", {28'b0, res_valid}, 32'd0);
      checkOutput("reset res_data", {23'b0, res_data}, 32'd0);
      checkOutput("reset mult_in_valid", {31'b0, mult_in_valid}, 32'd0);
      checkOutput("reset mult_in_a", {27'b0, mult_in_a}, 32'd0);
      checkOutput("reset mult_in_b", {28'b0, mult_in_b}, 32'd0);
      checkOutput("reset busy", {31'b0, busy}, 32'd0);
      checkOutput("reset err", {31'b0, err}, 32'd0);
      nextCycle();
      rst       = 1'b0;
      req_valid = '0;

      // Single products from the vector table, checking grant, issue and latency
      foreach (vecs[i]) begin
         nextCycle();
         req_valid = '0;
         req_valid[vecs[i].req] = 1'b1;
         applyStimulus(vecs[i].req, vecs[i].a, vecs[i].b);
         settle();
         checkOutput("single grant", {28'b0, req_ready}, 32'd1 << vecs[i].req);
         nextCycle();
         req_valid = '0;
         found = 1'b0;
         lat = 0;
         for (int c = 1; c <= LAT + 4 && !found; c++) begin
            settle();
            if (c == 1) begin
               checkOutput("issue valid", {31'b0, mult_in_valid}, 32'd1);
               checkOutput("issue a", {27'b0, mult_in_a}, {27'b0, vecs[i].a});
               checkOutput("issue b", {28'b0, mult_in_b}, {28'b0, vecs[i].b});
            end
            if (res_valid != '0) begin
               found = 1'b1;
               lat = c;
               checkOutput("single res_valid", {28'b0, res_valid}, 32'd1 << vecs[i].req);
               checkOutput("single res_data", {23'b0, res_data}, {23'b0, vecs[i].prod});
            end
         end
         checkOutput("single latency", lat, LAT + 2);
      end

      // Full contention from pointer 0: strict rotation, each requester twice
      doReset();
      for (int i = 0; i < 8; i++) begin
         nextCycle();
         req_valid = '1;
         for (int k = 0; k < R; k++) begin
            idx = i + ((k - (i % R) + R) % R);
            if (idx < 8) applyStimulus(k, cA[idx], cB[idx]);
         end
         settle();
         checkOutput("contention grant", {28'b0, req_ready}, 32'd1 << (i % R));
      end
      nextCycle();
      req_valid = '0;
      repeat (LAT + 4) settle();
      checkOutput("contention drained", expQ.size(), 32'd0);

      // Pointer rotation: grant 2 leaves ptr at 3, so 3 beats 0, then they alternate
      nextCycle();
      req_valid = 4'b0100;
      applyStimulus(2, 5'h05, 4'h3);
      settle();
      checkOutput("rotate grant 2", {28'b0, req_ready}, 32'h4);
      nextCycle();
      req_valid = 4'b1001;
      applyStimulus(0, 5'h11, 4'h2);
      applyStimulus(3, 5'h06, 4'hB);
      settle();
      checkOutput("rotate grant 3 first", {28'b0, req_ready}, 32'h8);
      nextCycle();
      applyStimulus(3, 5'h1E, 4'h7);
      settle();
      checkOutput("rotate grant 0 next", {28'b0, req_ready}, 32'h1);
      nextCycle();
      applyStimulus(0, 5'h09, 4'h4);
      settle();
      checkOutput("rotate grant 3 again", {28'b0, req_ready}, 32'h8);
      nextCycle();
      req_valid = '0;
      repeat (LAT + 4) settle();
      checkOutput("rotate drained", expQ.size(), 32'd0);

      // Reset two cycles after the third of three in-flight handshakes
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         req_valid = '1;
         applyStimulus(i, 5'h0B, 4'h5);
         settle();
      end
      nextCycle();
      req_valid = '0;
      settle();
      nextCycle();
      settle();
      nextCycle();
      #2;
      rst = 1'b1;
      req_valid = '1;
      #1;
      checkOutput("midrst req_ready", {28'b0, req_ready}, 32'd0);
      checkOutput("midrst res_valid", {28'b0, res_valid}, 32'd0);
      checkOutput("midrst res_data", {23'b0, res_data}, 32'd0);
      checkOutput("midrst mult_in_valid", {31'b0, mult_in_valid}, 32'd0);
      checkOutput("midrst mult_in_a", {27'b0, mult_in_a}, 32'd0);
      checkOutput("midrst mult_in_b", {28'b0, mult_in_b}, 32'd0);
      checkOutput("midrst busy", {31'b0, busy}, 32'd0);
      req_valid = '0;
      settle();
      nextCycle();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         settle();
         checkOutput("post-reset res_valid", {28'b0, res_valid}, 32'd0);
         checkOutput("post-reset busy", {31'b0, busy}, 32'd0);
      end

      // Spurious multiplier output with nothing in flight
      nextCycle();
      forceOutValid = 1'b1;
      settle();
      checkOutput("err before edge", {31'b0, err}, 32'd0);
      nextCycle();
      forceOutValid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         settle();
         checkOutput("err sticky", {31'b0, err}, 32'd1);
         checkOutput("err no res_valid", {28'b0, res_valid}, 32'd0);
      end
      nextCycle();
      rst = 1'b1;
      #1;
      checkOutput("err cleared by rst", {31'b0, err}, 32'd0);
      settle();
      nextCycle();
      rst = 1'b0;

      // Random soak; requesters hold valid and data until granted
      pending = '0;
      hsSeen  = '0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         nextCycle();
         for (int k = 0; k < R; k++) begin
            if (hsSeen[k]) pending[k] = 1'b0;
            if (!pending[k] && $urandom_range(0, 3) != 0) begin
               pending[k] = 1'b1;
               applyStimulus(k, M'($urandom), N'($urandom));
            end
         end
         req_valid = pending;
         settle();
         hsSeen = req_valid & req_ready;
      end
      nextCycle();
      req_valid = '0;
      found = 1'b0;
      for (int c = 0; c < LAT + 3 && !found; c++) begin
         settle();
         if (!busy) found = 1'b1;
      end
      checkOutput("soak busy drains", {31'b0, found}, 32'd1);
      repeat (LAT + 2) settle();
      checkOutput("soak all returned", expQ.size(), 32'd0);
      checkOutput("soak err clear", {31'b0, err}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
